s_axi_wr: RTL

S_AXI_WR -- requirements
Module: s_axi_wr

---
 rtl/s_axi_wr.sv | 135 +++++++++++++
 1 files changed

// File: rtl/s_axi_wr.sv
// AXI4-Lite write-only slave in front of a DEPTH x 32-bit register file.
// Address and data channels may arrive in either order; a single response is issued per write.
module s_axi_wr #(
    parameter int unsigned DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             s_axi_awvalid,
    output logic             s_axi_awready,
    input  logic [31:0]      s_axi_awaddr,
    input  logic             s_axi_wvalid,
    output logic             s_axi_wready,
    input  logic [31:0]      s_axi_wdata,
    input  logic [3:0]       s_axi_wstrb,
    output logic             s_axi_bvalid,
    input  logic             s_axi_bready,
    output logic [1:0]       s_axi_bresp,
    input  logic [IDX_W-1:0] i_dbg_idx,
    output logic [31:0]      o_dbg_data,
    output logic             o_wr_pulse
);

    localparam logic [31:0] SPAN   = 32'(4 * DEPTH);
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        GOT_ADDR,
        GOT_DATA,
        WRITE,
        RESP
    } state_t;

    state_t             state_q;
    logic [31:0]        awaddr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         wstrb_q;
    logic               bvalid_q;
    logic [1:0]         bresp_q;
    logic               wr_pulse_q;
    logic [31:0]        regs_q [DEPTH];

    logic               aw_hs;
    logic               w_hs;
    logic [32:0]        diff;
    logic               in_range;
    logic [IDX_W-1:0]   widx;

    // Ready flags decode the current state; forced low while reset is asserted.
    assign s_axi_awready = i_resetn && (state_q == IDLE || state_q == GOT_DATA);
    assign s_axi_wready  = i_resetn && (state_q == IDLE || state_q == GOT_ADDR);
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid && s_axi_wready;

    // 33-bit subtract: bit 32 flags an address below the base without overflow concerns.
    assign diff     = {1'b0, awaddr_q} - {1'b0, BASE_ADDR};
    assign in_range = !diff[32] && (diff[31:0] < SPAN);
    assign widx     = IDX_W'(diff[31:0] >> 2);

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign o_wr_pulse   = wr_pulse_q;
    assign o_dbg_data   = regs_q[i_dbg_idx];

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q    <= IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            wr_pulse_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_pulse_q <= 1'b0;
            if (aw_hs) begin
                awaddr_q <= s_axi_awaddr;
            end
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            case (state_q)
                IDLE: begin
                    if (aw_hs && w_hs) begin
                        state_q <= WRITE;
                    end else if (aw_hs) begin
                        state_q <= GOT_ADDR;
                    end else if (w_hs) begin
                        state_q <= GOT_DATA;
                    end
                end
                GOT_ADDR: begin
                    if (w_hs) begin
                        state_q <= WRITE;
                    end
                end
                GOT_DATA: begin
                    if (aw_hs) begin
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    state_q  <= RESP;
                    bvalid_q <= 1'b1;
                    bresp_q  <= in_range ? OKAY : SLVERR;
                    // An all-zero strobe is a legal no-op: OKAY response but no commit pulse.
                    if (in_range && (wstrb_q != 4'b0000)) begin
                        wr_pulse_q <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_q[b]) begin
                                regs_q[widx][8*b +: 8] <= wdata_q[8*b +: 8];
                            end
                        end
                    end
                end
                RESP: begin
                    if (s_axi_bready) begin
                        state_q  <= IDLE;
                        bvalid_q <= 1'b0;
                        bresp_q  <= OKAY;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
